uart_fft_loader: RTL and testbench



---
 rtl/uart_fft_loader_if.sv | 30 +++
 rtl/uart_fft_loader.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_fft_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fft_loader_if.sv
// uart_fft_loader_if: sample handshake between the UART loader and the FFT
// input buffer controller.
//   o_fft_data  assembled sample {real, imag}, driven by the loader
//   o_rx_valid  sample available, driven by the loader
//   i_rx_ready  sample accepted this cycle, driven by the FFT controller
//   o_rx_addr   sample index within the frame, driven by the loader
// Signal names keep the original port names of the loader.
interface uart_fft_loader_if #(
  parameter int length      = 32,
  parameter int DATA_LENGTH = 256
);
  logic [2*length-1:0]            o_fft_data;
  logic                           o_rx_valid;
  logic                           i_rx_ready;
  logic [$clog2(DATA_LENGTH)-1:0] o_rx_addr;

  modport master (
    output o_fft_data,
    output o_rx_valid,
    output o_rx_addr,
    input  i_rx_ready
  );

  modport slave (
    input  o_fft_data,
    input  o_rx_valid,
    input  o_rx_addr,
    output i_rx_ready
  );
endinterface

// File: rtl/uart_fft_loader.sv
// uart_fft_loader: receives a framed UART byte stream (SIG_LOAD command
// followed by DATA_LENGTH samples of 2*length bits, first byte = MSB) and
// hands each assembled sample to the FFT controller over a valid/ready bus.
// A one-byte skid register absorbs a byte arriving while a sample waits for
// acceptance; a second such byte is dropped and flags o_overrun.
// Ports:
//   i_clk        system clock (CLOCK_50)
//   i_rst        synchronous active-high reset
//   i_rxd        UART serial input
//   bus          uart_fft_loader_if.master: o_fft_data, o_rx_valid,
//                o_rx_addr out, i_rx_ready in
//   o_load_done  one-cycle pulse after the last sample of a frame is accepted
//   o_overrun    sticky lost-byte flag, cleared by SIG_LOAD/SIG_STOP in idle
//   o_timeout    one-cycle pulse when a partial sample is discarded
// Optional feature: define UART_LOADER_TIMEOUT_EN to enable the inter-byte
// timeout; without it o_timeout is tied to 0.
// Also contains uart_rx, the 8N1 UART receiver used by the loader.

module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state_q;
  logic          meta_q, sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    byte_q;
  logic          dv_q;

  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      state_q <= RX_IDLE;
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      meta_q <= i_Rx_Serial;
      sync_q <= meta_q;
      dv_q   <= 1'b0;
      unique case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          idx_q <= '0;
          if (!sync_q) state_q <= RX_START;
        end
        // Re-check the start bit at its centre to reject glitches.
        RX_START: begin
          if (cnt_q == CW'((CLKS_PER_BIT - 1) / 2)) begin
            cnt_q   <= '0;
            state_q <= sync_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q != CW'(CLKS_PER_BIT - 1)) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q         <= '0;
            byte_q[idx_q] <= sync_q;
            if (idx_q == 3'd7) state_q <= RX_STOP;
            else               idx_q   <= idx_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q != CW'(CLKS_PER_BIT - 1)) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q   <= '0;
            dv_q    <= 1'b1;
            state_q <= RX_IDLE;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign o_Rx_DV   = dv_q;
  assign o_Rx_Byte = byte_q;
endmodule

module uart_fft_loader #(
  parameter int length       = 32,
  parameter int CLKS_PER_BIT = 434,
  parameter int SIG_LOAD     = 76,
  parameter int SIG_STOP     = 83,
  parameter int DATA_LENGTH  = 256,
  parameter int TIMEOUT_CLKS = 43400
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rxd,
  uart_fft_loader_if.master  bus,
  output logic               o_load_done,
  output logic               o_overrun,
  output logic               o_timeout
);
  localparam int unsigned W   = 2 * length;
  localparam int unsigned BPS = W / 8;
  localparam int unsigned BCW = $clog2(BPS + 1);
  localparam int unsigned AW  = $clog2(DATA_LENGTH);
  localparam logic [7:0]  LOAD_B = 8'(SIG_LOAD);
  localparam logic [7:0]  STOP_B = 8'(SIG_STOP);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_PUSH, ST_DONE} state_t;

  logic       rx_dv;
  logic [7:0] rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_Clock     (i_clk),
    .i_Rst       (i_rst),
    .i_Rx_Serial (i_rxd),
    .o_Rx_DV     (rx_dv),
    .o_Rx_Byte   (rx_byte)
  );

  state_t         state_q;
  logic [BCW-1:0] byte_cnt_q;
  logic [AW-1:0]  addr_q;
  logic [W-1:0]   shift_q;
  logic [7:0]     skid_q;
  logic           skid_full_q;
  logic           valid_q;
  logic           done_q;
  logic           overrun_q;

  // In collect, a held skid byte is always consumed before the live byte.
  logic       src_valid;
  logic [7:0] src_byte;
  always_comb begin
    src_valid = skid_full_q | rx_dv;
    src_byte  = skid_full_q ? skid_q : rx_byte;
  end

`ifdef UART_LOADER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] timer_q;
  logic          timeout_hit;
  logic          timeout_q;

  assign timeout_hit = (timer_q == TW'(TIMEOUT_CLKS - 1));

  // Runs only while a sample is partially assembled; any consumed byte restarts it.
  always_ff @(posedge i_clk) begin
    if (i_rst || state_q != ST_COLLECT || byte_cnt_q == '0 || src_valid || timeout_hit)
      timer_q <= '0;
    else
      timer_q <= timer_q + 1'b1;
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      addr_q      <= '0;
      shift_q     <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (rx_dv) begin
            if (rx_byte == LOAD_B) begin
              state_q     <= ST_COLLECT;
              byte_cnt_q  <= '0;
              addr_q      <= '0;
              skid_full_q <= 1'b0;
              overrun_q   <= 1'b0;
            end else if (rx_byte == STOP_B) begin
              overrun_q <= 1'b0;
            end
          end
        end
        ST_COLLECT: begin
          // Draining the skid while a new byte lands refills it in the same cycle.
          if (skid_full_q) begin
            if (rx_dv) skid_q      <= rx_byte;
            else       skid_full_q <= 1'b0;
          end
          if (src_valid) begin
            shift_q <= W'({shift_q, src_byte});
            if (byte_cnt_q == BCW'(BPS - 1)) begin
              byte_cnt_q <= '0;
              valid_q    <= 1'b1;
              state_q    <= ST_PUSH;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
`ifdef UART_LOADER_TIMEOUT_EN
          else if (timeout_hit) begin
            byte_cnt_q <= '0;
            timeout_q  <= 1'b1;
          end
`endif
        end
        ST_PUSH: begin
          if (rx_dv) begin
            if (!skid_full_q) begin
              skid_q      <= rx_byte;
              skid_full_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          if (bus.i_rx_ready) begin
            valid_q <= 1'b0;
            if (addr_q == AW'(DATA_LENGTH - 1)) begin
              addr_q  <= '0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_COLLECT;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_fft_data = shift_q;
  assign bus.o_rx_valid = valid_q;
  assign bus.o_rx_addr  = addr_q;
  assign o_load_done    = done_q;
  assign o_overrun      = overrun_q;
endmodule

// File: tb/tb_uart_fft_loader.sv
// Scoreboard bench for uart_fft_loader: bytes are sent serially on i_rxd,
// expected samples are queued when a frame is issued, and a monitor pops
// and compares on every accepted transfer.
`timescale 1ns/1ps
module tb_uart_fft_loader;
  localparam int LEN = 16;
  localparam int CPB = 8;
  localparam int DL  = 16;
  localparam int TO  = 200;
  localparam int W   = 2 * LEN;
  localparam int BPS = W / 8;
  localparam int AW  = $clog2(DL);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic load_done, overrun, timeout;

  uart_fft_loader_if #(.length(LEN), .DATA_LENGTH(DL)) bus ();

  uart_fft_loader #(
    .length(LEN), .CLKS_PER_BIT(CPB), .SIG_LOAD(76), .SIG_STOP(83),
    .DATA_LENGTH(DL), .TIMEOUT_CLKS(TO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rxd(rxd), .bus(bus),
    .o_load_done(load_done), .o_overrun(overrun), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; logic [W-1:0] data;} exp_t;
  exp_t       exp_q[$];
  logic [7:0] stream[$];
  logic [7:0] model[$];

  int tests = 0, fails = 0;
  int done_cnt = 0, to_cnt = 0, valid_cycles = 0;
  int stall_addr = -1, stall_len = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxd = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cycles(CPB);
    end
    rxd = 1'b1;
    wait_cycles(CPB);
  endtask

  task automatic send_stream();
    foreach (stream[i]) send_byte(stream[i]);
  endtask

  // Reference: consecutive groups of BPS bytes, first byte most significant.
  task automatic push_model();
    for (int s = 0; s < model.size() / BPS; s++) begin
      exp_t e;
      e.addr = s;
      e.data = '0;
      for (int k = 0; k < BPS; k++) e.data = (e.data << 8) | W'(model[s*BPS+k]);
      exp_q.push_back(e);
    end
  endtask

  task automatic make_random(input int n);
    stream.delete();
    for (int i = 0; i < n; i++) stream.push_back(8'($urandom_range(0, 255)));
    model = stream;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_cnt < target; i++) wait_cycles(1);
    check("frame_done", 64'(done_cnt), 64'(target));
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 64'({bus.o_fft_data, bus.o_rx_valid, bus.o_rx_addr, load_done, overrun, timeout}), 64'd0);
  endtask

  // Ready driver: optional one-shot stall on a chosen address, else 1 or random.
  initial begin
    bus.i_rx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_addr >= 0 && bus.o_rx_valid && int'(bus.o_rx_addr) == stall_addr) begin
        bus.i_rx_ready = 1'b0;
        wait_cycles(stall_len);
        bus.i_rx_ready = 1'b1;
        stall_addr = -1;
      end else begin
        bus.i_rx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: samples at negedge, midway between input changes and clock edges.
  initial begin
    logic         prev_valid = 1'b0, prev_acc = 1'b0, last_acc = 1'b0, acc;
    logic [W-1:0] prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_acc   = 1'b0;
        last_acc   = 1'b0;
        continue;
      end
      if (last_acc || load_done) check("load_done_after_last", 64'(load_done), 64'(last_acc));
      if (load_done) done_cnt++;
      if (timeout) to_cnt++;
      if (bus.o_rx_valid) valid_cycles++;
      if (bus.o_rx_valid && prev_valid && !prev_acc)
        check("data_stable", 64'(bus.o_fft_data), 64'(prev_data));
      acc      = bus.o_rx_valid && bus.i_rx_ready;
      last_acc = 1'b0;
      if (acc) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_sample: got addr %0d data %0h, expected none", bus.o_rx_addr, bus.o_fft_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("addr", 64'(bus.o_rx_addr), 64'(e.addr));
          check("data", 64'(bus.o_fft_data), 64'(e.data));
          last_acc = (e.addr == DL - 1);
        end
      end
      prev_valid = bus.o_rx_valid;
      prev_acc   = acc;
      prev_data  = bus.o_fft_data;
    end
  end

  initial begin
    @(posedge clk);
    #1;
    wait_cycles(4);
    check_outputs_zero("reset_outputs");
    rst = 1'b0;
    wait_cycles(4);
    check_outputs_zero("idle_outputs");

    // Normal frame with the documented pattern, always ready.
    stream.delete();
    for (int n = 0; n < DL; n++) begin
      logic [W-1:0] s;
      s = {16'(16'hA000 + n), 16'(16'h5000 + n)};
      for (int k = BPS - 1; k >= 0; k--) stream.push_back(8'(s >> (8 * k)));
    end
    model = stream;
    push_model();
    valid_cycles = 0;
    send_byte(8'd76);
    send_stream();
    wait_done(1);
    check("zero_wait_valid_cycles", 64'(valid_cycles), 64'(DL));
    check("overrun_normal", 64'(overrun), 64'd0);

    // Idle filtering with random data and random ready.
    send_byte(8'h41);
    send_byte(8'd83);
    make_random(DL * BPS);
    push_model();
    rand_ready = 1'b1;
    send_byte(8'd76);
    send_stream();
    wait_done(2);
    rand_ready = 1'b0;
    check("overrun_random_ready", 64'(overrun), 64'd0);

    // Backpressure of 1.5 byte times: one byte parks in the skid.
    make_random(DL * BPS);
    push_model();
    stall_addr = 3;
    stall_len  = 15 * CPB;
    send_byte(8'd76);
    send_stream();
    wait_done(3);
    check("overrun_backpressure", 64'(overrun), 64'd0);

    // Backpressure of 2.5 byte times: skid takes the 1st byte of sample 4,
    // the 2nd is lost; one extra byte closes the frame.
    make_random(DL * BPS + 1);
    model.delete(4 * BPS + 1);
    push_model();
    stall_addr = 3;
    stall_len  = 25 * CPB;
    send_byte(8'd76);
    send_stream();
    wait_done(4);
    check("overrun_set", 64'(overrun), 64'd1);
    send_byte(8'h41);
    wait_cycles(4);
    check("overrun_sticky", 64'(overrun), 64'd1);
    send_byte(8'd83);
    wait_cycles(4);
    check("overrun_cleared", 64'(overrun), 64'd0);

    // Reset mid-frame after part of sample 10.
    make_random(10 * BPS + 2);
    push_model();
    send_byte(8'd76);
    send_stream();
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(3);
    check_outputs_zero("reset_midframe_outputs");
    rst = 1'b0;
    wait_cycles(2);
    check_outputs_zero("after_reset_outputs");
    check("queue_drained_before_reset", 64'(exp_q.size()), 64'd0);
    make_random(DL * BPS);
    push_model();
    send_byte(8'd76);
    send_stream();
    wait_done(5);

`ifdef UART_LOADER_TIMEOUT_EN
    // Partial sample abandoned; collection resumes at sample 0 without a new command.
    send_byte(8'd76);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)));
    wait_cycles(TO + 10);
    check("timeout_pulses", 64'(to_cnt), 64'd1);
    make_random(DL * BPS);
    push_model();
    send_stream();
    wait_done(6);
`else
    check("timeout_tied_low", 64'(to_cnt), 64'd0);
`endif

    wait_cycles(20);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
